// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the PC, drives the instruction memory
// word address, buffers {pc, instr} in a prefetch FIFO and hands entries to
// decode over valid/ready. Redirects flush the FIFO and reload the PC; a bad
// PC (misaligned or outside memory) parks the unit in FAULT until redirect.
// Optional build macro IFU_PERF_CNT_EN adds fetch and stall counters.
module ifetch_unit #(
  parameter logic [31:0] PC_RESET   = 32'h0040_0000,
  parameter logic [31:0] IMEM_BASE  = 32'h0040_0000,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [31:0]       fetch_pc,
  output logic [31:0]       fetch_instr,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              fetch_fault,
  output logic [31:0]       fault_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [32:0] MEM_BYTES = 33'(4) << ADDR_W;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  entry_t            mem_q [FIFO_DEPTH];

  logic [31:0]       off;
  logic              pc_bad;
  logic              push, pop, fault_set;

  // Address mapping and bad-PC detection from the PC register
  assign off       = pc_q - IMEM_BASE;
  assign imem_addr = off[ADDR_W+1:2];
  assign pc_bad    = (pc_q[1:0] != 2'b00) || ({1'b0, off} >= MEM_BYTES);

  // Head of FIFO toward decode; zero while empty
  assign fetch_valid = (count_q != '0);
  assign fetch_pc    = fetch_valid ? mem_q[rd_ptr_q].pc    : '0;
  assign fetch_instr = fetch_valid ? mem_q[rd_ptr_q].instr : '0;
  assign pop         = fetch_valid & fetch_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Next state and fetch decision; redirect overrides everything
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    fault_set = 1'b0;
    if (redirect_valid) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pc_bad) begin
            state_d   = ST_FAULT;
            fault_set = 1'b1;
          end else if ((count_q < CNT_W'(FIFO_DEPTH)) || pop) begin
            push = 1'b1;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // PC, pointers, occupancy and fault status
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= PC_RESET;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fetch_fault <= 1'b0;
      fault_pc    <= '0;
    end else if (redirect_valid) begin
      pc_q        <= redirect_pc;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fetch_fault <= 1'b0;
    end else begin
      if (push) begin
        pc_q     <= pc_q + 32'd4;
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
      if (fault_set) begin
        fetch_fault <= 1'b1;
        fault_pc    <= pc_q;
      end
    end
  end

  // FIFO storage; contents are don't-care outside the occupied window
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= '{pc: pc_q, instr: imem_instr};
  end

`ifdef IFU_PERF_CNT_EN
  // Performance counters: pushes and decode back-pressure cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (fetch_valid && !fetch_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
